// File: rtl/outbox_uart_tx.sv
// Reads one word at a time from the OUTBOX fifo and transmits it as a UART frame:
// a start bit, B data bits LSB first, then one stop bit. The line idles high.
module outbox_uart_tx #(
  parameter int B            = 8,
  parameter int CLKS_PER_BIT = 104,
  parameter int RD_LAT       = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_fifo_empty_n,
  input  logic [B-1:0] i_fifo_data,
  output logic         o_fifo_rd,
  output logic         o_tx,
  output logic         o_busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(B + 1);
  localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t             state, state_next;
  logic [WAIT_W-1:0]  wait_cnt, wait_next;
  logic [BAUD_W-1:0]  baud_cnt, baud_next;
  logic [BIT_W-1:0]   bit_cnt, bit_next;
  logic [B-1:0]       shift_reg, shift_next;
  logic               rd_next, tx_next, busy_next;
  logic               baud_last;

  assign baud_last = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    baud_next  = baud_cnt;
    bit_next   = bit_cnt;
    shift_next = shift_reg;
    rd_next    = 1'b0;
    tx_next    = 1'b1;

    // o_tx is taken from the current state, so it trails the state register by one cycle.
    // That lag gives the RD_LAT+1 start latency and keeps every bit exactly CLKS_PER_BIT long.
    case (state)
      ST_START: tx_next = 1'b0;
      ST_DATA:  tx_next = shift_reg[0];
      default:  tx_next = 1'b1;
    endcase

    case (state)
      ST_IDLE: begin
        if (i_fifo_empty_n) begin
          state_next = ST_WAIT;
          wait_next  = '0;
        end
      end
      ST_WAIT: begin
        if (!i_fifo_empty_n) begin
          state_next = ST_IDLE;
          wait_next  = '0;
        end else if (wait_cnt == WAIT_W'(RD_LAT - 1)) begin
          // The head word is valid by now: capture it and pop it in the same cycle.
          shift_next = i_fifo_data;
          rd_next    = 1'b1;
          state_next = ST_START;
          wait_next  = '0;
          baud_next  = '0;
        end else begin
          wait_next = wait_cnt + 1'b1;
        end
      end
      ST_START: begin
        if (baud_last) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = ST_DATA;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_next  = '0;
          shift_next = shift_reg >> 1;
          if (bit_cnt == BIT_W'(B - 1)) begin
            bit_next   = '0;
            state_next = ST_STOP;
          end else begin
            bit_next = bit_cnt + 1'b1;
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          baud_next  = '0;
          wait_next  = '0;
          state_next = i_fifo_empty_n ? ST_WAIT : ST_IDLE;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    busy_next = (state_next != ST_IDLE);
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      o_fifo_rd <= 1'b0;
      o_tx      <= 1'b1;
      o_busy    <= 1'b0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_next;
      baud_cnt  <= baud_next;
      bit_cnt   <= bit_next;
      shift_reg <= shift_next;
      o_fifo_rd <= rd_next;
      o_tx      <= tx_next;
      o_busy    <= busy_next;
    end
  end

endmodule
